// File: rtl/spi_ss_scheduler.sv
// Two-requester SPI master with round-robin arbitration and a bit-reversed
// slave-select decoder address. Mode 0, MSB first, one transfer at a time.
module spi_ss_scheduler #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [3:0]        addr0,
  input  logic [3:0]        addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [3:0]        ss_addr,
  output logic              ss_en
);

  localparam int BW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;

  state_t            state;
  logic [7:0]        div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              last_grant;
  logic              winner;
  logic              grant1;
  logic              div_wrap;
  logic [3:0]        win_addr;
  logic [DATA_W-1:0] win_data;

  // last_grant=1 means req1 was served last, so req0 wins a tie
  assign grant1   = req1 & (~req0 | ~last_grant);
  assign win_addr = grant1 ? addr1 : addr0;
  assign win_data = grant1 ? wdata1 : wdata0;
  assign div_wrap = (div_cnt == 8'(CLK_DIV - 1));

  // The transmit word is consumed from its top bit, so mosi is a flop output
  assign mosi = tx_sr[DATA_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      sclk       <= 1'b0;
      ss_addr    <= '0;
      ss_en      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= CS_SETUP;
            busy       <= 1'b1;
            ss_en      <= 1'b1;
            sclk       <= 1'b0;
            winner     <= grant1;
            last_grant <= grant1;
            ss_addr    <= {win_addr[0], win_addr[1], win_addr[2], win_addr[3]};
            tx_sr      <= win_data;
            div_cnt    <= '0;
          end
        end
        CS_SETUP: begin
          if (div_wrap) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SHIFT: begin
          // Each half-period ends with an sclk toggle: sample on rise, advance on fall
          if (div_wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end else if (bit_cnt == BW'(DATA_W - 1)) begin
              state <= CS_HOLD;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        CS_HOLD: begin
          if (div_wrap) begin
            div_cnt <= '0;
            state   <= DONE;
            ss_en   <= 1'b0;
            rdata   <= rx_sr;
            tx_sr   <= '0;
            ack0    <= ~winner;
            ack1    <= winner;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ss_scheduler.sv
// Directed bench for spi_ss_scheduler: a default instance with miso looped
// back from mosi and a CLK_DIV=1 instance with miso tied high.
module tb_spi_ss_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, ack0, ack1, busy, sclk, mosi, miso, ss_en;
  logic [3:0] addr0, addr1, ss_addr;
  logic [7:0] wdata0, wdata1, rdata;

  logic       req0_f, req1_f, ack0_f, ack1_f, busy_f, sclk_f, mosi_f, ss_en_f;
  logic [3:0] addr0_f, addr1_f, ss_addr_f;
  logic [7:0] wdata0_f, wdata1_f, rdata_f;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  assign miso = mosi;

  spi_ss_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_addr(ss_addr), .ss_en(ss_en)
  );

  spi_ss_scheduler #(.CLK_DIV(1), .DATA_W(8)) dut_f (
    .clk(clk), .rst_n(rst_n), .req0(req0_f), .req1(req1_f), .addr0(addr0_f), .addr1(addr1_f),
    .wdata0(wdata0_f), .wdata1(wdata1_f), .ack0(ack0_f), .ack1(ack1_f), .rdata(rdata_f),
    .busy(busy_f), .sclk(sclk_f), .mosi(mosi_f), .miso(1'b1), .ss_addr(ss_addr_f), .ss_en(ss_en_f)
  );

  // Runs one transfer on the default instance, observing 80 cycles after the sampling edge
  task automatic do_xfer(input bit who, input logic [3:0] a, input logic [7:0] d, input int drop_at,
                         output int ack_cyc, output int ack_cnt, output int en_cnt, output int pulses,
                         output logic [7:0] mosi_bits, output logic [3:0] addr_seen,
                         output logic mosi_first, output logic busy_after, output int wrong_ack);
    logic prev_sclk;
    logic my_ack;
    logic other_ack;
    ack_cyc = -1; ack_cnt = 0; en_cnt = 0; pulses = 0; mosi_bits = '0;
    addr_seen = 'x; mosi_first = 1'bx; busy_after = 1'bx; wrong_ack = 0; prev_sclk = 1'b0;
    @(negedge clk);
    if (who) begin req1 = 1'b1; addr1 = a; wdata1 = d; end
    else     begin req0 = 1'b1; addr0 = a; wdata0 = d; end
    @(posedge clk);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) begin addr_seen = ss_addr; mosi_first = mosi; end
      if (ss_en) en_cnt++;
      if (sclk && !prev_sclk) begin pulses++; mosi_bits = {mosi_bits[6:0], mosi}; end
      prev_sclk = sclk;
      my_ack    = who ? ack1 : ack0;
      other_ack = who ? ack0 : ack1;
      if (ack_cyc > 0 && k == ack_cyc + 1) busy_after = busy;
      if (my_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = k;
        if (who) req1 = 1'b0; else req0 = 1'b0;
      end
      if (other_ack) wrong_ack++;
      if (k == drop_at) begin
        if (who) req1 = 1'b0; else req0 = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ack0, ack1, rdata, busy, sclk, mosi, ss_addr, ss_en} !== 17'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b want all zero",
               {ack0, ack1, rdata, busy, sclk, mosi, ss_addr, ss_en});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ss_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_no_req: busy=%b ss_en=%b want 0 0", busy, ss_en);
    end
  endtask

  task automatic test_single();
    int ac, an, en, pu, wr;
    logic [7:0] mb;
    logic [3:0] as;
    logic mf, ba;
    do_xfer(1'b0, 4'd5, 8'hA5, 0, ac, an, en, pu, mb, as, mf, ba, wr);
    vectors++;
    if (as !== 4'b1010) begin miscompares++; $display("[TB] FAIL single_ss_addr: got %b want 1010", as); end
    vectors++;
    if (mf !== 1'b1) begin miscompares++; $display("[TB] FAIL single_setup_mosi: got %b want 1", mf); end
    vectors++;
    if (en != 72) begin miscompares++; $display("[TB] FAIL single_ss_en_len: got %0d want 72", en); end
    vectors++;
    if (pu != 8) begin miscompares++; $display("[TB] FAIL single_sclk_pulses: got %0d want 8", pu); end
    vectors++;
    if (mb !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_mosi_bits: got %h want a5", mb); end
    vectors++;
    if (ac != 73) begin miscompares++; $display("[TB] FAIL single_ack_cycle: got %0d want 73", ac); end
    vectors++;
    if (an != 1 || wr != 0) begin
      miscompares++; $display("[TB] FAIL single_ack_count: ack0=%0d ack1=%0d want 1 0", an, wr);
    end
    vectors++;
    if (rdata !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_rdata: got %h want a5", rdata); end
    vectors++;
    if (ba !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_after: got %b want 0", ba); end
  endtask

  task automatic test_fast_clkdiv();
    int ac, pu, r1, r2;
    logic prev;
    ac = -1; pu = 0; r1 = 0; r2 = 0; prev = 1'b0;
    @(negedge clk);
    req0_f = 1'b1; addr0_f = 4'd2; wdata0_f = 8'h3C;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (sclk_f && !prev) begin
        pu++;
        if (pu == 1) r1 = k;
        if (pu == 2) r2 = k;
      end
      prev = sclk_f;
      if (k == 1) begin
        vectors++;
        if (ss_addr_f !== 4'b0100) begin
          miscompares++; $display("[TB] FAIL fast_ss_addr: got %b want 0100", ss_addr_f);
        end
      end
      if (ack0_f && ac < 0) begin ac = k; req0_f = 1'b0; end
    end
    vectors++;
    if (r2 - r1 != 2) begin miscompares++; $display("[TB] FAIL fast_sclk_period: got %0d want 2", r2 - r1); end
    vectors++;
    if (pu != 8) begin miscompares++; $display("[TB] FAIL fast_sclk_pulses: got %0d want 8", pu); end
    vectors++;
    if (ac != 19) begin miscompares++; $display("[TB] FAIL fast_ack_cycle: got %0d want 19", ac); end
    vectors++;
    if (rdata_f !== 8'hFF) begin miscompares++; $display("[TB] FAIL fast_rdata: got %h want ff", rdata_f); end
  endtask

  task automatic test_round_robin();
    logic       exp_win;
    logic [3:0] exp_addr;
    int         found;
    apply_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; addr0 = 4'd3; addr1 = 4'd12; wdata0 = 8'h11; wdata1 = 8'h22;
    for (int t = 0; t < 4; t++) begin
      exp_win  = t[0];
      exp_addr = exp_win ? 4'b0011 : 4'b1100;
      found = 0;
      for (int k = 0; k < 100 && found == 0; k++) begin
        @(negedge clk);
        if (ack0 || ack1) begin
          found = 1;
          vectors++;
          if (ack1 !== exp_win || ack0 !== ~exp_win) begin
            miscompares++;
            $display("[TB] FAIL rr_grant_%0d: ack0=%b ack1=%b want ack1=%b", t, ack0, ack1, exp_win);
          end
          vectors++;
          if (ss_addr !== exp_addr) begin
            miscompares++; $display("[TB] FAIL rr_ss_addr_%0d: got %b want %b", t, ss_addr, exp_addr);
          end
          if (t == 3) begin req0 = 1'b0; req1 = 1'b0; end
        end
      end
      if (found == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL rr_timeout_%0d: no ack within 100 cycles, want one", t);
        req0 = 1'b0; req1 = 1'b0;
        t = 4;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_req_drop();
    int ac, an, en, pu, wr;
    logic [7:0] mb;
    logic [3:0] as;
    logic mf, ba;
    do_xfer(1'b1, 4'd7, 8'h96, 10, ac, an, en, pu, mb, as, mf, ba, wr);
    vectors++;
    if (ac != 73 || an != 1 || wr != 0) begin
      miscompares++;
      $display("[TB] FAIL drop_ack: cycle=%0d ack1=%0d ack0=%0d want 73 1 0", ac, an, wr);
    end
    vectors++;
    if (rdata !== 8'h96) begin miscompares++; $display("[TB] FAIL drop_rdata: got %h want 96", rdata); end
    vectors++;
    if (ba !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_busy_after: got %b want 0", ba); end
  endtask

  task automatic test_mid_reset();
    int ac, an, en, pu, wr, stray;
    logic [7:0] mb;
    logic [3:0] as;
    logic mf, ba;
    @(negedge clk);
    req0 = 1'b1; addr0 = 4'd9; wdata0 = 8'h5A;
    @(posedge clk);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ack0, ack1, rdata, busy, sclk, mosi, ss_addr, ss_en} !== 17'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %b want all zero",
               {ack0, ack1, rdata, busy, sclk, mosi, ss_addr, ss_en});
    end
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (ack0 || ack1 || busy) stray++;
    end
    vectors++;
    if (stray != 0) begin miscompares++; $display("[TB] FAIL midreset_no_ack: got %0d active cycles want 0", stray); end
    do_xfer(1'b0, 4'd1, 8'h3C, 0, ac, an, en, pu, mb, as, mf, ba, wr);
    vectors++;
    if (ac != 73 || rdata !== 8'h3C || as !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL midreset_recover: cycle=%0d rdata=%h ss_addr=%b want 73 3c 1000", ac, rdata, as);
    end
  endtask

  task automatic test_back_to_back();
    int found, low;
    @(negedge clk);
    req0 = 1'b1; addr0 = 4'd15; wdata0 = 8'h81;
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      @(negedge clk);
      if (ack0) found = 1;
    end
    vectors++;
    if (found == 0 || ss_addr !== 4'b1111 || ss_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: ack=%0d ss_addr=%b ss_en=%b want 1 1111 0", found, ss_addr, ss_en);
    end
    addr0 = 4'd0;
    low = 1;
    for (int k = 0; k < 10 && ss_en !== 1'b1; k++) begin
      @(negedge clk);
      if (ss_en !== 1'b1) low++;
    end
    vectors++;
    if (low != 2) begin miscompares++; $display("[TB] FAIL b2b_gap: got %0d want 2", low); end
    vectors++;
    if (ss_addr !== 4'b0000) begin miscompares++; $display("[TB] FAIL b2b_second_addr: got %b want 0000", ss_addr); end
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      @(negedge clk);
      if (ack0) begin found = 1; req0 = 1'b0; end
    end
    vectors++;
    if (found == 0 || rdata !== 8'h81) begin
      miscompares++; $display("[TB] FAIL b2b_second_ack: ack=%0d rdata=%h want 1 81", found, rdata);
    end
    req0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    req0_f = 1'b0; req1_f = 1'b0; addr0_f = '0; addr1_f = '0; wdata0_f = '0; wdata1_f = '0;
    test_reset();
    test_single();
    test_fast_clkdiv();
    test_round_robin();
    test_req_drop();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_ss_scheduler.md
SPI_SS_SCHEDULER -- requirements
Module: spi_ss_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning the SCLK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the bits per transfer.
REQ-003 SHALL have a single clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0, req1  input  1 each  transfer requests; level, held until the matching ack.
REQ-007 addr0, addr1  input  4 each  target slave index 0..15 per requester.
REQ-008 wdata0, wdata1  input  DATA_W each  transmit word per requester.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse per requester.
REQ-010 rdata  output  DATA_W  received word; valid in the ack cycle and held until the next ack.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-013 mosi  output  1  serial data out, MSB first.
REQ-014 miso  input  1  serial data in, MSB first.
REQ-015 ss_addr  output  4  slave-select decoder address, bit-reversed: ss_addr[0]=index[3], ss_addr[1]=index[2], ss_addr[2]=index[1], ss_addr[3]=index[0].
REQ-016 ss_en  output  1  decoder data input; high exactly while the selected slave is active.

Function
REQ-017 SHALL implement the states IDLE, CS_SETUP, SHIFT, CS_HOLD and DONE.
REQ-018 IDLE, no request -> stay in IDLE.
REQ-019 IDLE, any request -> CS_SETUP next cycle, with the grant decided, and the winner's addr/wdata latched on that edge.
REQ-020 Arbitration SHALL be round-robin: on a simultaneous request, the requester not served last wins; after reset req0 has priority.
REQ-021 Requests SHALL be sampled only in IDLE; a request deasserting mid-transfer SHALL NOT abort the transfer, and the ack SHALL still issue.
REQ-022 CS_SETUP SHALL last CLK_DIV cycles, with ss_en=1, sclk=0 and mosi=MSB of the latched word.
REQ-023 SHIFT SHALL last 2*DATA_W*CLK_DIV cycles, organised as DATA_W bit periods.
REQ-024 Each bit period SHALL be sclk low for CLK_DIV cycles, then sclk high for CLK_DIV cycles.
REQ-025 miso SHALL be sampled on the clk edge where sclk rises.
REQ-026 mosi SHALL advance to the next bit on the clk edge where sclk falls; no advance after the last bit.
REQ-027 CS_HOLD SHALL last CLK_DIV cycles, with sclk=0 and ss_en=1.
REQ-028 DONE SHALL last 1 cycle: ss_en=0, the winner's ack=1, rdata updated with the shifted-in word, then return to IDLE.
REQ-029 ss_addr SHALL stay stable from CS_SETUP through DONE; in IDLE it holds its last value (0 after reset).
REQ-030 Latency: ack is high in cycle 1+(2*DATA_W+2)*CLK_DIV after the IDLE sampling edge, i.e. 73 cycles with defaults.
REQ-031 The minimum spacing between ss_en-low and the next ss_en-high SHALL be 2 cycles (DONE, IDLE).
REQ-032 The internal divider counter SHALL wrap at CLK_DIV-1 with no off-by-one; a bit counter of width clog2(DATA_W)+1 SHALL count DATA_W bits.

Reset
REQ-033 Asserting rst_n low at any time, including mid-SHIFT, SHALL immediately force IDLE, sclk=0, mosi=0, ss_en=0, ss_addr=0, ack0=ack1=0, rdata=0, busy=0 and round-robin priority to req0.
REQ-034 After rst_n deasserts, the first arbitration SHALL occur on the first clk edge in IDLE.

Verification
REQ-035 req0, addr0=5, wdata0=0xA5, miso loopback from mosi, defaults -> ss_addr=4'b1010, ss_en high for 72 cycles, 8 sclk pulses, mosi 1,0,1,0,0,1,0,1, ack0 at cycle 73, rdata=0xA5.
REQ-036 req0 and req1 asserted together, repeated twice (addr0=3, addr1=12) -> grant order req0, req1, req0, req1; ss_addr 4'b1100, then 4'b0011.
REQ-037 CLK_DIV=1, DATA_W=8, miso tied 1 -> sclk period 2 cycles, ack at cycle 19, rdata=0xFF.
REQ-038 rst_n pulsed low during bit 4 of SHIFT -> all outputs at reset values asynchronously; no ack; the next request completes normally.
REQ-039 req1 dropped after 10 cycles of busy -> transfer completes, ack1 pulses once, busy falls the cycle after DONE.
REQ-040 addr=15, then addr=0 back-to-back -> ss_addr 4'b1111, then 4'b0000; ss_en low for exactly 2 cycles between transfers.
